// File: rtl/pipeline_controller_pkg.sv
// Shared types and defaults for the pipeline sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_ctrl_pkg;

  localparam int STATE_W = 3;

  localparam int RESET_FLUSH_CYCLES_DEF = 2;
  localparam int DRAIN_CYCLES_DEF       = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_RST_FLUSH = 3'd0,
    ST_RUN       = 3'd1,
    ST_DRAIN     = 3'd2,
    ST_HALTED    = 3'd3,
    ST_STEP      = 3'd4
  } pipe_state_e;

endpackage

// File: rtl/pipeline_controller_perf_counter.sv
// Free-running event counter with synchronous reset and increment enable.
// Latency: count reflects an increment one cycle after inc is sampled.
// Backpressure: none; wraps modulo 2^CNT_W.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count enabled events, clear on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_controller.sv
// Sequencer merging hazard, memory-wait, reset-flush and host run/halt/step into stage enables/flushes.
// Latency: state registered; enables/flushes combinational from state and inputs (zero-cycle).
// Backpressure: mem_busy_i freezes every stage register; PERF_CNT_EN adds cycle/stall counters.
module pipeline_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int RESET_FLUSH_CYCLES = RESET_FLUSH_CYCLES_DEF,
  parameter int DRAIN_CYCLES       = DRAIN_CYCLES_DEF,
  parameter int CNT_W              = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               halt_req_i,
  input  logic               resume_req_i,
  input  logic               step_req_i,
  input  logic               hz_pc_write_en_i,
  input  logic               hz_if_id_write_en_i,
  input  logic               hz_if_id_flush_i,
  input  logic               hz_id_ex_flush_i,
  input  logic               mem_busy_i,
  output logic               pc_write_en_o,
  output logic               if_id_write_en_o,
  output logic               id_ex_write_en_o,
  output logic               ex_mem_write_en_o,
  output logic               mem_wb_write_en_o,
  output logic               if_id_flush_o,
  output logic               id_ex_flush_o,
  output logic               ex_mem_flush_o,
  output logic               mem_wb_flush_o,
  output logic               halted_o,
`ifdef PERF_CNT_EN
  output logic [CNT_W-1:0]   cycle_cnt_o,
  output logic [CNT_W-1:0]   stall_cnt_o,
`endif
  output logic [STATE_W-1:0] state_o
);

  // One shared down-counter serves both the reset flush and the drain
  localparam int CTR_MAX = (RESET_FLUSH_CYCLES > DRAIN_CYCLES) ? RESET_FLUSH_CYCLES : DRAIN_CYCLES;
  localparam int CTR_W   = $clog2(CTR_MAX + 1);

  pipe_state_e      state;
  logic [CTR_W-1:0] cnt;
  logic             halt_pend;
  logic             halt_ok;

  // A halt is only accepted when the front end can advance cleanly, so nothing in IF/ID is lost
  assign halt_ok = (halt_req_i | halt_pend) & hz_pc_write_en_i & ~hz_if_id_flush_i & ~mem_busy_i;

  // State, shared counter and pending-halt flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_RST_FLUSH;
      cnt       <= CTR_W'(RESET_FLUSH_CYCLES);
      halt_pend <= 1'b0;
    end else begin
      case (state)
        ST_RST_FLUSH: begin
          cnt <= cnt - CTR_W'(1);
          if (cnt == CTR_W'(1)) state <= ST_RUN;
        end
        ST_RUN: begin
          if (halt_ok) begin
            state     <= ST_DRAIN;
            cnt       <= CTR_W'(DRAIN_CYCLES);
            halt_pend <= 1'b0;
          end else if (halt_req_i) begin
            halt_pend <= 1'b1;
          end
        end
        ST_DRAIN: begin
          // Busy cycles retire nothing, so they do not count toward the drain
          if (!mem_busy_i) begin
            cnt <= cnt - CTR_W'(1);
            if (cnt == CTR_W'(1)) state <= ST_HALTED;
          end
        end
        ST_HALTED: begin
          if (resume_req_i)    state <= ST_RUN;
          else if (step_req_i) state <= ST_STEP;
        end
        ST_STEP: begin
          if (!mem_busy_i) begin
            state <= ST_DRAIN;
            cnt   <= CTR_W'(DRAIN_CYCLES);
          end
        end
        default: begin
          state     <= ST_RST_FLUSH;
          cnt       <= CTR_W'(RESET_FLUSH_CYCLES);
          halt_pend <= 1'b0;
        end
      endcase
    end
  end

  // Per-stage enables and flushes from current state and live hazard/memory inputs
  always_comb begin
    pc_write_en_o     = 1'b0;
    if_id_write_en_o  = 1'b0;
    id_ex_write_en_o  = 1'b0;
    ex_mem_write_en_o = 1'b0;
    mem_wb_write_en_o = 1'b0;
    if_id_flush_o     = 1'b0;
    id_ex_flush_o     = 1'b0;
    ex_mem_flush_o    = 1'b0;
    mem_wb_flush_o    = 1'b0;
    halted_o          = 1'b0;
    case (state)
      ST_RST_FLUSH: begin
        id_ex_write_en_o  = 1'b1;
        ex_mem_write_en_o = 1'b1;
        mem_wb_write_en_o = 1'b1;
        if_id_flush_o     = 1'b1;
        id_ex_flush_o     = 1'b1;
        ex_mem_flush_o    = 1'b1;
        mem_wb_flush_o    = 1'b1;
      end
      ST_RUN, ST_STEP: begin
        // While busy everything freezes; hazard flushes re-assert once busy clears
        if (!mem_busy_i) begin
          pc_write_en_o     = hz_pc_write_en_i;
          if_id_write_en_o  = hz_if_id_write_en_i;
          id_ex_write_en_o  = 1'b1;
          ex_mem_write_en_o = 1'b1;
          mem_wb_write_en_o = 1'b1;
          if_id_flush_o     = hz_if_id_flush_i;
          id_ex_flush_o     = hz_id_ex_flush_i;
        end
      end
      ST_DRAIN: begin
        // Front end stops fetching but a branch resolving in EX must still redirect the PC
        if (!mem_busy_i) begin
          pc_write_en_o     = hz_if_id_flush_i;
          if_id_flush_o     = hz_if_id_flush_i;
          id_ex_write_en_o  = 1'b1;
          id_ex_flush_o     = 1'b1;
          ex_mem_write_en_o = 1'b1;
          mem_wb_write_en_o = 1'b1;
        end
      end
      ST_HALTED: begin
        halted_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_o = state;

`ifdef PERF_CNT_EN
  logic cycle_inc;
  logic stall_inc;

  assign cycle_inc = (state == ST_RUN) | (state == ST_STEP) | (state == ST_DRAIN);
  assign stall_inc = ((state == ST_RUN) | (state == ST_STEP)) & (mem_busy_i | ~hz_pc_write_en_i);

  perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (cycle_inc),
    .count (cycle_cnt_o)
  );

  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (stall_inc),
    .count (stall_cnt_o)
  );
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: reset flush, hazards, halt/drain, step/resume, mid-drain reset.
// Latency: inputs driven at negedge, outputs sampled 1ns later, state advances on posedge.
// Backpressure: mem_busy exercised in RUN, DRAIN and STEP.
module tb_pipeline_controller;

  logic clk = 1'b0;
  logic rst, halt_req, resume_req, step_req;
  logic hz_pc, hz_ifid_we, hz_ifid_fl, hz_idex_fl, mem_busy;
  logic pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic ifid_fl, idex_fl, exmem_fl, memwb_fl, halted;
  logic [2:0] state;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt, stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_controller dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .halt_req_i          (halt_req),
    .resume_req_i        (resume_req),
    .step_req_i          (step_req),
    .hz_pc_write_en_i    (hz_pc),
    .hz_if_id_write_en_i (hz_ifid_we),
    .hz_if_id_flush_i    (hz_ifid_fl),
    .hz_id_ex_flush_i    (hz_idex_fl),
    .mem_busy_i          (mem_busy),
    .pc_write_en_o       (pc_we),
    .if_id_write_en_o    (ifid_we),
    .id_ex_write_en_o    (idex_we),
    .ex_mem_write_en_o   (exmem_we),
    .mem_wb_write_en_o   (memwb_we),
    .if_id_flush_o       (ifid_fl),
    .id_ex_flush_o       (idex_fl),
    .ex_mem_flush_o      (exmem_fl),
    .mem_wb_flush_o      (memwb_fl),
    .halted_o            (halted),
`ifdef PERF_CNT_EN
    .cycle_cnt_o         (cycle_cnt),
    .stall_cnt_o         (stall_cnt),
`endif
    .state_o             (state)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Apply one cycle of inputs at negedge and let combinational outputs settle
  task automatic drive(input logic r, input logic pc, input logic iwe, input logic ifl,
                       input logic efl, input logic busy, input logic h, input logic rs,
                       input logic st);
    @(negedge clk);
    rst = r; hz_pc = pc; hz_ifid_we = iwe; hz_ifid_fl = ifl; hz_idex_fl = efl;
    mem_busy = busy; halt_req = h; resume_req = rs; step_req = st;
    #1;
  endtask

  // we = {pc, if_id, id_ex, ex_mem, mem_wb}; fl = {if_id, id_ex, ex_mem, mem_wb}
  task automatic expect_out(input string tag, input logic [2:0] st, input logic [4:0] we,
                            input logic [3:0] fl, input logic hl);
    chk(tag, {19'b0, state, pc_we, ifid_we, idex_we, exmem_we, memwb_we,
              ifid_fl, idex_fl, exmem_fl, memwb_fl, halted},
             {19'b0, st, we, fl, hl});
  endtask

  // Hazard-free, not busy, no host request
  task automatic idle(input logic h, input logic rs, input logic st);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, h, rs, st);
  endtask

  initial begin
    rst = 1'b1; halt_req = 1'b0; resume_req = 1'b0; step_req = 1'b0;
    hz_pc = 1'b1; hz_ifid_we = 1'b1; hz_ifid_fl = 1'b0; hz_idex_fl = 1'b0; mem_busy = 1'b0;
    repeat (3) @(posedge clk);

    // Post-reset flush: two cycles, then RUN
    idle(0, 0, 0);             expect_out("rstflush0", 3'd0, 5'b00111, 4'b1111, 1'b0);
`ifdef PERF_CNT_EN
    chk("cycle_cnt_rst", cycle_cnt, 32'd0);
    chk("stall_cnt_rst", stall_cnt, 32'd0);
`endif
    idle(0, 0, 0);             expect_out("rstflush1", 3'd0, 5'b00111, 4'b1111, 1'b0);
    drive(0, 1, 1, 1, 0, 0, 0, 0, 0); expect_out("run_branch", 3'd1, 5'b11111, 4'b1000, 1'b0);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0); expect_out("run_loaduse", 3'd1, 5'b00111, 4'b0100, 1'b0);
    drive(0, 1, 1, 1, 0, 1, 0, 0, 0); expect_out("run_busy", 3'd1, 5'b00000, 4'b0000, 1'b0);
`ifdef PERF_CNT_EN
    chk("cycle_cnt_run", cycle_cnt, 32'd2);
    chk("stall_cnt_run", stall_cnt, 32'd1);
`endif

    // Clean halt: acceptance cycle is normal RUN, then 3 drain cycles
    idle(1, 0, 0);             expect_out("halt_accept", 3'd1, 5'b11111, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(0, 0, 0);           expect_out($sformatf("drain%0d", i), 3'd2, 5'b00111, 4'b0100, 1'b0);
    end
    idle(1, 0, 0);             expect_out("halted", 3'd3, 5'b00000, 4'b0000, 1'b1);
    idle(0, 1, 0);             expect_out("halt_ign_halted", 3'd3, 5'b00000, 4'b0000, 1'b1);
    idle(0, 1, 1);             expect_out("resume_run", 3'd1, 5'b11111, 4'b0000, 1'b0);

    // Blocked halt: held pending across two PC-stall cycles
    drive(0, 0, 1, 0, 0, 0, 1, 0, 0); expect_out("halt_blk0", 3'd1, 5'b01111, 4'b0000, 1'b0);
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0); expect_out("halt_blk1", 3'd1, 5'b01111, 4'b0000, 1'b0);
    idle(0, 0, 0);             expect_out("halt_pend_acc", 3'd1, 5'b11111, 4'b0000, 1'b0);

    // Branch in first drain cycle, then memory wait stretches the drain
    drive(0, 1, 1, 1, 0, 0, 0, 0, 0); expect_out("drain_branch", 3'd2, 5'b10111, 4'b1100, 1'b0);
    drive(0, 1, 1, 0, 0, 1, 0, 0, 0); expect_out("drain_busy0", 3'd2, 5'b00000, 4'b0000, 1'b0);
    drive(0, 1, 1, 0, 0, 1, 0, 0, 0); expect_out("drain_busy1", 3'd2, 5'b00000, 4'b0000, 1'b0);
    idle(0, 0, 0);             expect_out("drain_after0", 3'd2, 5'b00111, 4'b0100, 1'b0);
    idle(0, 0, 0);             expect_out("drain_after1", 3'd2, 5'b00111, 4'b0100, 1'b0);

    // Single step held off by memory wait
    drive(0, 1, 1, 0, 0, 1, 0, 0, 1); expect_out("step_req", 3'd3, 5'b00000, 4'b0000, 1'b1);
    drive(0, 1, 1, 0, 0, 1, 0, 0, 0); expect_out("step_busy0", 3'd4, 5'b00000, 4'b0000, 1'b0);
    drive(0, 1, 1, 0, 0, 1, 0, 0, 0); expect_out("step_busy1", 3'd4, 5'b00000, 4'b0000, 1'b0);
    idle(0, 0, 0);             expect_out("step_run", 3'd4, 5'b11111, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(0, 0, 0);           expect_out($sformatf("step_drain%0d", i), 3'd2, 5'b00111, 4'b0100, 1'b0);
    end
    idle(0, 1, 1);             expect_out("both_req", 3'd3, 5'b00000, 4'b0000, 1'b1);
    idle(0, 0, 0);             expect_out("resume_wins", 3'd1, 5'b11111, 4'b0000, 1'b0);

    // Reset mid-drain; halt during reset flush must not be remembered
    idle(1, 0, 0);             expect_out("halt2_accept", 3'd1, 5'b11111, 4'b0000, 1'b0);
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0); expect_out("drain_rst", 3'd2, 5'b00111, 4'b0100, 1'b0);
    idle(1, 0, 0);             expect_out("rst2_flush0", 3'd0, 5'b00111, 4'b1111, 1'b0);
    idle(0, 0, 0);             expect_out("rst2_flush1", 3'd0, 5'b00111, 4'b1111, 1'b0);
    idle(0, 0, 0);             expect_out("rst2_run", 3'd1, 5'b11111, 4'b0000, 1'b0);
    idle(0, 0, 0);             expect_out("no_stale_halt", 3'd1, 5'b11111, 4'b0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
Name: pipeline_controller

Overview:
- Top-level sequencer for the 5-stage pipeline registers. Sits between the hazard unit and the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Merges hazard-unit stall/flush requests with data-memory wait, post-reset flush, and a host run/halt/single-step protocol.
- Produces the final per-stage write-enable and flush signals.

Parameters:
- RESET_FLUSH_CYCLES, 2, cycles spent in RST_FLUSH after reset release (min 1).
- DRAIN_CYCLES, 3, non-busy cycles needed to retire EX, MEM and WB contents before HALTED (min 1).
- CNT_W, 32, performance counter width (PERF_CNT_EN only).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- halt_req_i  in  1  host halt pulse
- resume_req_i  in  1  host resume pulse
- step_req_i  in  1  host single-step pulse
- hz_pc_write_en_i  in  1  hazard unit PC enable
- hz_if_id_write_en_i  in  1  hazard unit IF/ID enable
- hz_if_id_flush_i  in  1  hazard unit IF/ID flush (taken branch/jump)
- hz_id_ex_flush_i  in  1  hazard unit ID/EX flush
- mem_busy_i  in  1  data memory not ready; freeze whole pipeline
- pc_write_en_o, if_id_write_en_o, id_ex_write_en_o, ex_mem_write_en_o, mem_wb_write_en_o  out  1 each  stage register enables
- if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o  out  1 each  stage clears (flush overrides enable at the register)
- halted_o  out  1  high only in HALTED
- state_o  out  3  current state encoding

Behaviour:
- Single clock domain. rst_i is synchronous and active-high, and is sampled on clk_i.
- Reset forces state RST_FLUSH, loads counter=RESET_FLUSH_CYCLES, and clears halt_pend. This applies from any state and mid-DRAIN/STEP; nothing is retained.
- State encoding: RST_FLUSH=0, RUN=1, DRAIN=2, HALTED=3, STEP=4. Next state is registered; outputs are combinational from state and inputs.
- RST_FLUSH (these are also the reset values of all outputs):
  - pc_we=0, if_id_we=0, all other we=1, all four flushes=1, halted_o=0.
  - Counter decrements each cycle; at 1 the next state is RUN.
- RUN, mem_busy_i=0:
  - pc_we=hz_pc_write_en_i, if_id_we=hz_if_id_write_en_i, if_id_flush=hz_if_id_flush_i, id_ex_flush=hz_id_ex_flush_i.
  - id_ex/ex_mem/mem_wb we=1; ex_mem/mem_wb flush=0.
- RUN, mem_busy_i=1: all we=0, all flushes=0. Hazard flushes are held off; their sources stay frozen, so they are re-asserted once busy clears.
- halt_pend is set by halt_req_i in RUN.
- RUN -> DRAIN when (halt_req_i|halt_pend) and hz_pc_write_en_i=1, hz_if_id_flush_i=0 and mem_busy_i=0.
  - The acceptance cycle itself behaves as normal RUN.
  - On the transition, counter loads DRAIN_CYCLES and halt_pend clears.
  - While the halt is blocked, halt_pend stays set.
- DRAIN:
  - pc_we=hz_if_id_flush_i, so a taken branch now in EX still redirects the PC. if_id_flush=hz_if_id_flush_i. if_id_we=0.
  - id_ex_flush=1 (bubbles); ex_mem/mem_wb we=1.
  - mem_busy_i=1 overrides with all we=0 and all flushes=0, and the counter holds.
  - Counter decrements only on non-busy cycles; on reaching 0 the next state is HALTED.
- HALTED: all we=0, all flushes=0, halted_o=1.
  - resume_req_i -> RUN. step_req_i -> STEP. If both arrive together, resume wins.
- STEP: identical to RUN outputs for exactly one non-busy cycle, then -> DRAIN with counter=DRAIN_CYCLES. While mem_busy_i=1 it stays in STEP, frozen.
- Ignored requests:
  - halt_req_i outside RUN.
  - resume_req_i/step_req_i outside HALTED; these are dropped, not latched.

Optional Feature:
- PERF_CNT_EN
  - Defined: adds ports cycle_cnt_o and stall_cnt_o, each CNT_W bits, reset to 0 and wrapping modulo 2^CNT_W.
  - cycle_cnt_o increments every cycle in RUN, STEP or DRAIN.
  - stall_cnt_o increments in RUN/STEP when mem_busy_i=1 or hz_pc_write_en_i=0.
  - Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - pipe_state_e enum (3-bit, encodings above).
  - STATE_W=3.
  - Default RESET_FLUSH_CYCLES and DRAIN_CYCLES constants.
- One sub-module, perf_counter (CNT_W-bit counter with synchronous reset and increment enable), instantiated twice, only under PERF_CNT_EN.

Test Plan:
- Reset: rst_i=1 for 3 cycles, then release -> 2 cycles with state_o=0, pc_we=0, all flushes=1; cycle 3 state_o=1 and outputs mirror hazard inputs.
- Load-use in RUN: hz_pc_we=0, hz_if_id_we=0, hz_id_ex_flush=1 -> pc_we_o=0, if_id_we_o=0, id_ex_flush_o=1, ex_mem/mem_wb we=1.
- Halt, clean: halt pulse with no hazard -> next cycle DRAIN with pc_we=0, if_id_we=0, id_ex_flush=1 for 3 cycles; then halted_o=1 and all we=0.
- Halt blocked: halt pulse while hz_pc_we=0 for 2 cycles -> stays RUN; enters DRAIN on the edge after the first hazard-free cycle.
- Branch and memory wait in DRAIN:
  - hz_if_id_flush=1 in the first DRAIN cycle -> pc_we_o=1, if_id_flush_o=1, id_ex_flush_o=1.
  - mem_busy=1 for 2 cycles mid-drain -> counter holds, and HALTED is reached 2 cycles later than it would be otherwise.
- Step/resume: step_req in HALTED with mem_busy=1 for 2 cycles -> STEP frozen, then one RUN cycle, DRAIN for 3, HALTED. A simultaneous resume+step in HALTED -> state_o=1.
